// File: rtl/strobe_counter_multi_if.sv
// Bus bundle for strobe_counter_multi: per-channel control in, counts and flags out.
// STROBE_COUNTER_SNAPSHOT_EN adds the snap / snap_count pair.
interface strobe_counter_multi_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10
);
    logic [N_CH-1:0]       clear;
    logic [N_CH-1:0]       strob;
    logic [CNT_W-1:0]      limit;
    logic                  mode;
    logic [N_CH*CNT_W-1:0] count;
    logic [N_CH-1:0]       tc;
    logic [N_CH-1:0]       ovf;
`ifdef STROBE_COUNTER_SNAPSHOT_EN
    logic                  snap;
    logic [N_CH*CNT_W-1:0] snap_count;

    modport master (
        output clear, strob, limit, mode, snap,
        input  count, tc, ovf, snap_count
    );
    modport slave (
        input  clear, strob, limit, mode, snap,
        output count, tc, ovf, snap_count
    );
`else
    modport master (
        output clear, strob, limit, mode,
        input  count, tc, ovf
    );
    modport slave (
        input  clear, strob, limit, mode,
        output count, tc, ovf
    );
`endif
endinterface

// File: rtl/strobe_counter_multi.sv
// Multi-channel strobe counter with shared terminal value, wrap/saturate mode and sticky overflow.
// STROBE_COUNTER_SNAPSHOT_EN enables an atomic snapshot register of all channel counts.
module strobe_counter_multi #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 10
) (
    input  logic                   clk,
    input  logic                   reset,
    strobe_counter_multi_if.slave  bus
);

    logic [N_CH-1:0][CNT_W-1:0] cnt_d, cnt_q;
    logic [N_CH-1:0]            tc_d, tc_q;
    logic [N_CH-1:0]            ovf_d, ovf_q;
    logic [CNT_W-1:0]           inc;

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = '0;
        ovf_d = ovf_q;
        inc   = '0;
        for (int i = 0; i < N_CH; i++) begin
            inc = cnt_q[i] + CNT_W'(1);
            if (bus.clear[i]) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (bus.strob[i]) begin
                // >= so a lowered limit catches counters already above it
                if (cnt_q[i] >= bus.limit) begin
                    ovf_d[i] = 1'b1;
                    if (!bus.mode) begin
                        cnt_d[i] = '0;
                        tc_d[i]  = 1'b1;
                    end
                end else begin
                    cnt_d[i] = inc;
                    tc_d[i]  = bus.mode && (inc == bus.limit);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            tc_q  <= '0;
            ovf_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.count = cnt_q;
    assign bus.tc    = tc_q;
    assign bus.ovf   = ovf_q;

`ifdef STROBE_COUNTER_SNAPSHOT_EN
    logic [N_CH*CNT_W-1:0] snap_d, snap_q;

    // Captures pre-update counts so the snapshot is coherent across channels
    always_comb begin
        snap_d = snap_q;
        if (bus.snap) snap_d = cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) snap_q <= '0;
        else        snap_q <= snap_d;
    end

    assign bus.snap_count = snap_q;
`endif

endmodule

// File: tb/tb_strobe_counter_multi.sv
// Scoreboard bench for strobe_counter_multi; expected outputs queued at drive time, compared after the edge.
module tb_strobe_counter_multi;
    localparam int N_CH  = 4;
    localparam int CNT_W = 10;

    typedef struct packed {
        logic [N_CH*CNT_W-1:0] count;
        logic [N_CH-1:0]       tc;
        logic [N_CH-1:0]       ovf;
        logic [N_CH*CNT_W-1:0] snap_count;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    strobe_counter_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

    strobe_counter_multi #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    exp_t sb_q[$];

    logic [CNT_W-1:0]      m_cnt [N_CH];
    logic [N_CH-1:0]       m_ovf;
    logic [N_CH*CNT_W-1:0] m_snap;
    logic                  snap_drv = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N_CH*CNT_W-1:0] pack_model();
        logic [N_CH*CNT_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = m_cnt[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) m_cnt[i] = '0;
        m_ovf  = '0;
        m_snap = '0;
    endtask

    // Reference behaviour of one rising edge, pushed onto the scoreboard
    task automatic model_edge(input logic [N_CH-1:0] clr, input logic [N_CH-1:0] stb);
        exp_t e;
        logic [N_CH-1:0] tc;
        int lim, c;
        tc  = '0;
        lim = int'(bus.limit);
        if (snap_drv) m_snap = pack_model();
        for (int i = 0; i < N_CH; i++) begin
            c = int'(m_cnt[i]);
            if (clr[i]) begin
                m_cnt[i] = '0;
                m_ovf[i] = 1'b0;
            end else if (stb[i]) begin
                if (c >= lim) begin
                    m_ovf[i] = 1'b1;
                    if (bus.mode == 1'b0) begin
                        m_cnt[i] = '0;
                        tc[i]    = 1'b1;
                    end
                end else begin
                    m_cnt[i] = CNT_W'(c + 1);
                    tc[i]    = (bus.mode == 1'b1) && (c + 1 == lim);
                end
            end
        end
        e.count      = pack_model();
        e.tc         = tc;
        e.ovf        = m_ovf;
        e.snap_count = m_snap;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic [N_CH-1:0] clr, input logic [N_CH-1:0] stb);
        exp_t e;
        bus.clear = clr;
        bus.strob = stb;
`ifdef STROBE_COUNTER_SNAPSHOT_EN
        bus.snap = snap_drv;
`endif
        model_edge(clr, stb);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check("count", 64'(bus.count), 64'(e.count));
            check("tc", 64'(bus.tc), 64'(e.tc));
            check("ovf", 64'(bus.ovf), 64'(e.ovf));
`ifdef STROBE_COUNTER_SNAPSHOT_EN
            check("snap_count", 64'(bus.snap_count), 64'(e.snap_count));
`endif
        end
        bus.clear = '0;
        bus.strob = '0;
    endtask

    function automatic logic [CNT_W-1:0] ch(input int i);
        return bus.count[i*CNT_W +: CNT_W];
    endfunction

    initial begin
        reset     = 1'b0;
        bus.clear = '0;
        bus.strob = '0;
        bus.limit = 10'd5;
        bus.mode  = 1'b0;
`ifdef STROBE_COUNTER_SNAPSHOT_EN
        bus.snap = 1'b0;
`endif
        model_reset();
        #12;
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_tc", 64'(bus.tc), 64'd0);
        check("rst_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // Wrap, limit 5: six strobes on ch0
        for (int k = 0; k < 6; k++) step(4'b0000, 4'b0001);
        check("t1_cnt0", 64'(ch(0)), 64'd0);
        check("t1_tc", 64'(bus.tc), 64'b0001);
        check("t1_ovf", 64'(bus.ovf), 64'b0001);
        check("t1_others", 64'(bus.count[N_CH*CNT_W-1:CNT_W]), 64'd0);
        step(4'b0000, 4'b0000);
        check("t1_tc_drop", 64'(bus.tc), 64'd0);

        // Saturate, limit 3: five strobes on ch1
        bus.mode  = 1'b1;
        bus.limit = 10'd3;
        step(4'b0000, 4'b0010);
        step(4'b0000, 4'b0010);
        step(4'b0000, 4'b0010);
        check("t2_cnt1_3", 64'(ch(1)), 64'd3);
        check("t2_tc", 64'(bus.tc), 64'b0010);
        check("t2_ovf_pre", 64'(bus.ovf[1]), 64'd0);
        step(4'b0000, 4'b0010);
        check("t2_ovf", 64'(bus.ovf[1]), 64'd1);
        check("t2_tc_sat", 64'(bus.tc), 64'd0);
        step(4'b0000, 4'b0010);
        check("t2_cnt1_hold", 64'(ch(1)), 64'd3);

        // Clear wins over a simultaneous strobe
        bus.mode  = 1'b0;
        bus.limit = 10'd9;
        for (int k = 0; k < 4; k++) step(4'b0000, 4'b0100);
        check("t3_cnt2_4", 64'(ch(2)), 64'd4);
        step(4'b0100, 4'b0100);
        check("t3_cnt2", 64'(ch(2)), 64'd0);
        check("t3_ovf2", 64'(bus.ovf[2]), 64'd0);
        check("t3_tc2", 64'(bus.tc[2]), 64'd0);

        // Limit lowered below the current count
        for (int k = 0; k < 7; k++) step(4'b0000, 4'b1000);
        bus.limit = 10'd4;
        step(4'b0000, 4'b1000);
        check("t4_cnt3", 64'(ch(3)), 64'd0);
        check("t4_tc3", 64'(bus.tc[3]), 64'd1);
        check("t4_ovf3", 64'(bus.ovf[3]), 64'd1);

        // limit = 0 in both modes
        step(4'b1111, 4'b0000);
        bus.limit = 10'd0;
        step(4'b0000, 4'b0001);
        check("lim0_wrap_tc", 64'(bus.tc[0]), 64'd1);
        check("lim0_wrap_ovf", 64'(bus.ovf[0]), 64'd1);
        bus.mode = 1'b1;
        step(4'b0000, 4'b0010);
        check("lim0_sat_tc", 64'(bus.tc[1]), 64'd0);
        check("lim0_sat_ovf", 64'(bus.ovf[1]), 64'd1);
        check("lim0_sat_cnt", 64'(ch(1)), 64'd0);

        // Async reset mid-count
        bus.mode  = 1'b0;
        bus.limit = 10'd9;
        step(4'b0000, 4'b1111);
        step(4'b0000, 4'b1111);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check("t5_count", 64'(bus.count), 64'd0);
        check("t5_tc", 64'(bus.tc), 64'd0);
        check("t5_ovf", 64'(bus.ovf), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        step(4'b0000, 4'b0001);
        check("t5_resume", 64'(ch(0)), 64'd1);

`ifdef STROBE_COUNTER_SNAPSHOT_EN
        // Snapshot with counts {2,0,5,1}
        step(4'b1111, 4'b0000);
        step(4'b0000, 4'b1101);
        step(4'b0000, 4'b0101);
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0100);
        snap_drv = 1'b1;
        step(4'b0000, 4'b1111);
        snap_drv = 1'b0;
        check("t6_snap", 64'(bus.snap_count), {24'd0, 10'd1, 10'd5, 10'd0, 10'd2});
        check("t6_count", 64'(bus.count), {24'd0, 10'd2, 10'd6, 10'd1, 10'd3});
        step(4'b0000, 4'b1111);
        check("t6_snap_hold", 64'(bus.snap_count), {24'd0, 10'd1, 10'd5, 10'd0, 10'd2});
`endif

        // Random mix of clear/strobe/mode/limit
        for (int k = 0; k < 60; k++) begin
            if ((k % 10) == 0) bus.limit = CNT_W'($urandom_range(6));
            bus.mode = 1'($urandom_range(1));
            snap_drv = 1'($urandom_range(1));
            step(N_CH'($urandom_range(15) & $urandom_range(15)), N_CH'($urandom_range(15)));
        end
        snap_drv = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
